// File: rtl/sum_stationary_pkg.sv
// Shared definitions for the sum_stationary_stream matrix-multiply block:
// the sequencing FSM state encoding and the accumulator-width rule.
package sum_stationary_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FLUSH,
        ST_DRAIN
    } state_t;

    // Full-precision product width plus enough headroom for max_k additions.
    function automatic int acc_width_f(input int data_width, input int max_k);
        return 2 * data_width + $clog2(max_k);
    endfunction

endpackage

// File: rtl/sum_stationary_pe.sv
// One processing element of the output-stationary array: multiply-accumulate
// into a local accumulator and forward the operands east (a) and south (b).
// Signed arithmetic is selected with the SUM_STATIONARY_SIGNED_EN macro.
module sum_stationary_pe
    import sum_stationary_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 19
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  clr,
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic [DATA_WIDTH-1:0] b_in,
    output logic [DATA_WIDTH-1:0] a_out,
    output logic [DATA_WIDTH-1:0] b_out,
    output logic [ACC_WIDTH-1:0]  acc
);

    localparam int PROD_WIDTH = 2 * DATA_WIDTH;

    logic [ACC_WIDTH-1:0] prod_ext;

`ifdef SUM_STATIONARY_SIGNED_EN
    logic signed [PROD_WIDTH-1:0] prod;
    // Operands are widened with their sign before the multiply so the full
    // two's-complement product is kept, then sign-extended to the accumulator.
    assign prod     = PROD_WIDTH'($signed(a_in)) * PROD_WIDTH'($signed(b_in));
    assign prod_ext = ACC_WIDTH'(prod);
`else
    logic [PROD_WIDTH-1:0] prod;
    // Zero-extended operands give the full unsigned product.
    assign prod     = PROD_WIDTH'(a_in) * PROD_WIDTH'(b_in);
    assign prod_ext = ACC_WIDTH'(prod);
`endif

    // Clear wins over enable so a job boundary and a reset look identical.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge value, independent of block ordering.
        if (clr) begin
            acc   <= '0;
            a_out <= '0;
            b_out <= '0;
        end else if (en) begin
            acc   <= acc + prod_ext;
            a_out <= a_in;
            b_out <= b_in;
        end
    end

endmodule

// File: rtl/sum_stationary_stream.sv
// Streaming output-stationary ROWS x COLS matrix multiplier C = A * B.
// Each accepted beat carries one column of A and one row of B; after K beats
// the array is flushed with zeros and C is read out one row per handshake.
// Define SUM_STATIONARY_SIGNED_EN for two's-complement operands and results.
module sum_stationary_stream
    import sum_stationary_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int MAX_K      = 8,
    parameter int ACC_WIDTH  = acc_width_f(DATA_WIDTH, MAX_K)
) (
    input  logic                         clk,
    input  logic                         reset_n_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [DATA_WIDTH-1:0]        a_i [ROWS],
    input  logic [DATA_WIDTH-1:0]        b_i [COLS],
    input  logic [$clog2(MAX_K+1)-1:0]   k_len_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
`ifdef SUM_STATIONARY_SIGNED_EN
    output logic signed [ACC_WIDTH-1:0]  out_data_o [COLS],
`else
    output logic [ACC_WIDTH-1:0]         out_data_o [COLS],
`endif
    output logic [$clog2(ROWS)-1:0]      out_row_o,
    output logic                         out_last_o
);

    localparam int K_W       = $clog2(MAX_K + 1);
    localparam int ROW_W     = $clog2(ROWS);
    // Zero steps needed for the last product to reach PE(ROWS-1, COLS-1).
    localparam int FLUSH_LEN = ROWS + COLS - 2;
    localparam int FL_W      = $clog2(FLUSH_LEN + 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    state_t             state;
    logic               ready_q;
    logic               valid_q;
    logic               last_q;
    logic [ROW_W-1:0]   row_q;
    logic [K_W-1:0]     k_q;
    logic [K_W-1:0]     beat_cnt;
    logic [FL_W-1:0]    flush_cnt;

    logic               accept;
    logic               row_done;
    logic               job_done;
    logic               advance;
    logic               clear;
    logic [K_W-1:0]     k_eff;

    logic [DATA_WIDTH-1:0] a_inj  [ROWS];
    logic [DATA_WIDTH-1:0] b_inj  [COLS];
    logic [DATA_WIDTH-1:0] a_west [ROWS];
    logic [DATA_WIDTH-1:0] b_north[COLS];
    logic [DATA_WIDTH-1:0] a_fwd  [ROWS][COLS];
    logic [DATA_WIDTH-1:0] b_fwd  [ROWS][COLS];
    logic [ACC_WIDTH-1:0]  acc    [ROWS][COLS];
    logic                  unused_fwd;

    // Beats are refused while reset is held, even before the edge lands.
    assign in_ready_o = ready_q & reset_n_i;
    assign accept     = in_valid_i & in_ready_o;
    assign row_done   = valid_q & out_ready_i;
    assign job_done   = row_done & last_q;
    assign advance    = accept | (state == ST_FLUSH);
    assign clear      = ~reset_n_i | job_done;
    assign k_eff      = (k_len_i == '0) ? K_W'(MAX_K) : k_len_i;

    assign out_valid_o = valid_q;
    assign out_row_o   = row_q;
    assign out_last_o  = last_q;

    // Array edge inputs: live operands while loading, zeros while flushing.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path (here via
        // the full loop) so no latch can be inferred.
        for (int i = 0; i < ROWS; i++) a_inj[i] = (state == ST_FLUSH) ? '0 : a_i[i];
        for (int j = 0; j < COLS; j++) b_inj[j] = (state == ST_FLUSH) ? '0 : b_i[j];
    end

    // Row i of A is delayed i array steps before entering PE(i,0).
    for (genvar i = 0; i < ROWS; i++) begin : g_skew_a
        if (i == 0) begin : g_direct
            assign a_west[i] = a_inj[i];
        end else begin : g_delay
            logic [DATA_WIDTH-1:0] sr [i];
            // Shift one stage per array step; cleared with the accumulators.
            always_ff @(posedge clk) begin
                // NOTE: these small flop arrays are cleared explicitly because
                // stale operands would leak into the next job's sums.
                if (clear) begin
                    for (int s = 0; s < i; s++) sr[s] <= '0;
                end else if (advance) begin
                    sr[0] <= a_inj[i];
                    for (int s = 1; s < i; s++) sr[s] <= sr[s-1];
                end
            end
            assign a_west[i] = sr[i-1];
        end
    end

    // Column j of B is delayed j array steps before entering PE(0,j).
    for (genvar j = 0; j < COLS; j++) begin : g_skew_b
        if (j == 0) begin : g_direct
            assign b_north[j] = b_inj[j];
        end else begin : g_delay
            logic [DATA_WIDTH-1:0] sr [j];
            // Shift one stage per array step; cleared with the accumulators.
            always_ff @(posedge clk) begin
                if (clear) begin
                    for (int s = 0; s < j; s++) sr[s] <= '0;
                end else if (advance) begin
                    sr[0] <= b_inj[j];
                    for (int s = 1; s < j; s++) sr[s] <= sr[s-1];
                end
            end
            assign b_north[j] = sr[j-1];
        end
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_row
        for (genvar j = 0; j < COLS; j++) begin : g_col
            logic [DATA_WIDTH-1:0] a_in;
            logic [DATA_WIDTH-1:0] b_in;
            if (j == 0) begin : g_a_edge
                assign a_in = a_west[i];
            end else begin : g_a_inner
                assign a_in = a_fwd[i][j-1];
            end
            if (i == 0) begin : g_b_edge
                assign b_in = b_north[j];
            end else begin : g_b_inner
                assign b_in = b_fwd[i-1][j];
            end
            sum_stationary_pe #(
                .DATA_WIDTH (DATA_WIDTH),
                .ACC_WIDTH  (ACC_WIDTH)
            ) u_pe (
                .clk   (clk),
                .en    (advance),
                .clr   (clear),
                .a_in  (a_in),
                .b_in  (b_in),
                .a_out (a_fwd[i][j]),
                .b_out (b_fwd[i][j]),
                .acc   (acc[i][j])
            );
        end
    end

    // The east/south edge forwards have no consumer; fold them away.
    always_comb begin
        unused_fwd = 1'b0;
        for (int i = 0; i < ROWS; i++) unused_fwd = unused_fwd ^ (^a_fwd[i][COLS-1]);
        for (int j = 0; j < COLS; j++) unused_fwd = unused_fwd ^ (^b_fwd[ROWS-1][j]);
    end

    // Result row mux; the bus reads zero whenever no row is being offered.
    always_comb begin
        for (int j = 0; j < COLS; j++) out_data_o[j] = valid_q ? acc[row_q][j] : '0;
    end

    // Job sequencer: load K beats, flush the skew, then drain rows in order.
    always_ff @(posedge clk) begin
        if (!reset_n_i) begin
            state     <= ST_IDLE;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            row_q     <= '0;
            k_q       <= '0;
            beat_cnt  <= '0;
            flush_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        k_q      <= k_eff;
                        beat_cnt <= K_W'(1);
                        if (k_eff == K_W'(1)) begin
                            state     <= ST_FLUSH;
                            ready_q   <= 1'b0;
                            flush_cnt <= '0;
                        end else begin
                            state <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        beat_cnt <= beat_cnt + K_W'(1);
                        if (beat_cnt + K_W'(1) == k_q) begin
                            state     <= ST_FLUSH;
                            ready_q   <= 1'b0;
                            flush_cnt <= '0;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt == FL_W'(FLUSH_LEN - 1)) begin
                        state   <= ST_DRAIN;
                        valid_q <= 1'b1;
                        row_q   <= '0;
                        last_q  <= (ROWS == 1);
                    end else begin
                        flush_cnt <= flush_cnt + FL_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (row_done) begin
                        if (last_q) begin
                            state    <= ST_IDLE;
                            ready_q  <= 1'b1;
                            valid_q  <= 1'b0;
                            last_q   <= 1'b0;
                            row_q    <= '0;
                            k_q      <= '0;
                            beat_cnt <= '0;
                        end else begin
                            row_q  <= row_q + ROW_W'(1);
                            last_q <= (row_q + ROW_W'(1) == LAST_ROW);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
